// File: rtl/spi_resp_pkg.sv
// Shared constants, FSM encoding and address helper for the SPI configuration responder.
package spi_resp_pkg;

  localparam int FRAME_BITS = 24;
  localparam int INSTR_BITS = 16;
  localparam int ADDR_W     = 15;
  localparam int DATA_W     = 8;
  localparam int CNT_W      = 5;

  // bit_cnt values seen on the rising edge that completes each field
  localparam logic [CNT_W-1:0] CNT_INSTR_LAST = 5'd15;
  localparam logic [CNT_W-1:0] CNT_FRAME_LAST = 5'd23;
  localparam logic [CNT_W-1:0] CNT_FRAME      = 5'd24;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INSTR = 3'd1,
    WDATA = 3'd2,
    RDATA = 3'd3,
    DONE  = 3'd4
  } state_e;

  function automatic logic addr_hit(input logic [ADDR_W-1:0] addr,
                                    input int unsigned        num_regs);
    return ({17'd0, addr} < num_regs);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous SPI pin, plus a history flop for edge pulses.
module spi_sync_edge (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;
  logic prev_d, prev_q;

  // Reset low so a pin already low at release produces no falling edge.
  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchronizer and edge-history registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder: 24-bit R/W frames against an internal 8-bit register file,
// with all SPI pins oversampled on the system clock.
module spi_responder
  import spi_resp_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     spi_csn,
  input  logic                     spi_sclk,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  output logic                     spi_miso_oe,
  output logic                     wr_strobe,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     frame_err,
  output logic [NUM_REGS*8-1:0]    cfg_regs
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic csn_lvl_s, csn_rise_s, csn_fall_s;
  logic sclk_lvl_unused, sclk_rise_raw_s, sclk_fall_raw_s;
  logic mosi_lvl_s, mosi_rise_unused, mosi_fall_unused;
  logic sclk_rise_s, sclk_fall_s;

  spi_sync_edge u_sync_csn (
    .clk(clk), .rstn(rstn), .din(spi_csn),
    .level(csn_lvl_s), .rise(csn_rise_s), .fall(csn_fall_s)
  );

  spi_sync_edge u_sync_sclk (
    .clk(clk), .rstn(rstn), .din(spi_sclk),
    .level(sclk_lvl_unused), .rise(sclk_rise_raw_s), .fall(sclk_fall_raw_s)
  );

  spi_sync_edge u_sync_mosi (
    .clk(clk), .rstn(rstn), .din(spi_mosi),
    .level(mosi_lvl_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  assign sclk_rise_s = sclk_rise_raw_s & ~csn_lvl_s;
  assign sclk_fall_s = sclk_fall_raw_s & ~csn_lvl_s;

  state_e                  state_d, state_q;
  logic [CNT_W-1:0]        bit_cnt_d, bit_cnt_q;
  logic [FRAME_BITS-3:0]   rx_d, rx_q;
  logic [DATA_W-1:0]       tx_d, tx_q;
  logic                    miso_d, miso_q;
  logic                    miso_oe_d, miso_oe_q;
  logic                    wr_strobe_d, wr_strobe_q;
  logic [ADDR_W-1:0]       wr_addr_d, wr_addr_q;
  logic [DATA_W-1:0]       wr_data_d, wr_data_q;
  logic                    frame_err_d, frame_err_q;
  logic [NUM_REGS*8-1:0]   regs_d, regs_q;

  // The R/W bit has left rx by the 24th edge, so rx_shift is frame bits 22:0 there.
  logic [FRAME_BITS-2:0]   rx_shift_s;
  logic [ADDR_W-1:0]       instr_addr_s;
  logic [ADDR_W-1:0]       frame_addr_s;
  logic [DATA_W-1:0]       frame_data_s;
  logic [IDX_W-1:0]        rd_idx_s;
  logic [IDX_W-1:0]        wr_idx_s;
  logic [DATA_W-1:0]       rd_data_s;

  // Field extraction and register-file read mux.
  always_comb begin
    rx_shift_s   = {rx_q, mosi_lvl_s};
    instr_addr_s = rx_shift_s[ADDR_W-1:0];
    frame_addr_s = rx_shift_s[FRAME_BITS-2:DATA_W];
    frame_data_s = rx_shift_s[DATA_W-1:0];
    rd_idx_s     = instr_addr_s[IDX_W-1:0];
    wr_idx_s     = frame_addr_s[IDX_W-1:0];
    if (addr_hit(instr_addr_s, NUM_REGS)) begin
      rd_data_s = regs_q[{rd_idx_s, 3'b000} +: DATA_W];
    end else begin
      rd_data_s = 8'h00;
    end
  end

  // Frame FSM: next state, shift registers, commit and outputs.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    regs_d      = regs_q;

    if (csn_rise_s) begin
      state_d   = IDLE;
      bit_cnt_d = 5'd0;
      miso_d    = 1'b0;
      miso_oe_d = 1'b0;
      if ((bit_cnt_q != 5'd0) && (bit_cnt_q < CNT_FRAME)) begin
        frame_err_d = 1'b1;
      end else begin
        frame_err_d = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (csn_fall_s) begin
            state_d   = INSTR;
            bit_cnt_d = 5'd0;
            rx_d      = '0;
          end else begin
            state_d = IDLE;
          end
        end

        INSTR: begin
          if (sclk_rise_s) begin
            rx_d      = rx_shift_s[FRAME_BITS-3:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == CNT_INSTR_LAST) begin
              if (rx_shift_s[INSTR_BITS-1]) begin
                state_d = RDATA;
                tx_d    = rd_data_s;
              end else begin
                state_d = WDATA;
              end
            end else begin
              state_d = INSTR;
            end
          end else begin
            state_d = INSTR;
          end
        end

        WDATA: begin
          if (sclk_rise_s) begin
            rx_d      = rx_shift_s[FRAME_BITS-3:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == CNT_FRAME_LAST) begin
              state_d = DONE;
              if (addr_hit(frame_addr_s, NUM_REGS)) begin
                wr_strobe_d                             = 1'b1;
                wr_addr_d                               = frame_addr_s;
                wr_data_d                               = frame_data_s;
                regs_d[{wr_idx_s, 3'b000} +: DATA_W]    = frame_data_s;
              end else begin
                wr_strobe_d = 1'b0;
              end
            end else begin
              state_d = WDATA;
            end
          end else begin
            state_d = WDATA;
          end
        end

        RDATA: begin
          if (sclk_rise_s) begin
            rx_d      = rx_shift_s[FRAME_BITS-3:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == CNT_FRAME_LAST) begin
              state_d = DONE;
            end else begin
              state_d = RDATA;
            end
          end else if (sclk_fall_s) begin
            miso_d    = tx_q[DATA_W-1];
            miso_oe_d = 1'b1;
            tx_d      = {tx_q[DATA_W-2:0], 1'b0};
          end else begin
            state_d = RDATA;
          end
        end

        // The falling edge after the last read bit releases MISO.
        DONE: begin
          if (sclk_fall_s) begin
            miso_d    = 1'b0;
            miso_oe_d = 1'b0;
          end else begin
            state_d = DONE;
          end
        end

        default: begin
          state_d   = IDLE;
          bit_cnt_d = 5'd0;
          miso_d    = 1'b0;
          miso_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 5'd0;
      rx_q        <= '0;
      tx_q        <= 8'h00;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 15'd0;
      wr_data_q   <= 8'h00;
      frame_err_q <= 1'b0;
      regs_q      <= {(NUM_REGS*8){1'b0}};
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
      regs_q      <= regs_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = miso_oe_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_err   = frame_err_q;
  assign cfg_regs    = regs_q;

endmodule

// File: doc/spi_responder.md
# spi_responder

SPI target (responder) for the configuration link. It receives 24-bit SPI mode-0 frames from the SPI initiator side (one R/W bit, 15 address bits, 8 data bits) and keeps an internal 8-bit register file. It drives read data back on MISO and exposes register contents plus a write strobe to the device model. All logic runs on the 100 MHz system clock, and the SPI pins are oversampled.

## Interface

- NUM_REGS, 16, number of implemented 8-bit registers; must be ≤ 256 and a power of two.
- clk  in  1  system clock, 100 MHz.
- rstn  in  1  asynchronous, active-low reset.
- spi_csn  in  1  chip select, active low; asynchronous to clk.
- spi_sclk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0); asynchronous; max clk/8.
- spi_mosi  in  1  serial data in, MSB first.
- spi_miso  out  1  serial data out, MSB first.
- spi_miso_oe  out  1  1 while read data is being driven.
- wr_strobe  out  1  one-cycle pulse when a register write commits.
- wr_addr  out  15  address of the last write; held between writes.
- wr_data  out  8  data of the last write; held between writes.
- frame_err  out  1  one-cycle pulse when a frame is aborted.
- cfg_regs  out  NUM_REGS*8  flat register image; register i is at [8i+7:8i].

## Operation

- Frame format: bit 23 is R/W (1 = read), bits 22:8 are the address, bits 7:0 are the data. Bits arrive MSB first.
- MOSI is sampled on SCLK rising edges. MISO changes on SCLK falling edges.
- An address is implemented if address < NUM_REGS. Writes to unimplemented addresses are dropped: no wr_strobe, no register change. Reads of unimplemented addresses return 8'h00.
- State machine:
  - IDLE: waits for CSN falling, then clears bit_cnt and goes to INSTR.
  - INSTR: shifts 16 bits. After the 16th rising edge, the R/W bit selects the next state.
    - Read: goes to RDATA and loads the tx shift register with the addressed register.
    - Write: goes to WDATA.
  - WDATA: shifts 8 bits. After the 24th rising edge:
    - commits the write when the address is implemented;
    - pulses wr_strobe;
    - updates wr_addr and wr_data;
    - goes to DONE.
  - RDATA: drives MISO with the data MSB first. After the 24th rising edge, goes to DONE.
  - DONE: further SCLK edges are ignored. CSN rising returns to IDLE.
- CSN rising in any state returns to IDLE.
  - If bit_cnt is between 1 and 23, frame_err pulses and nothing is committed.
  - If bit_cnt is 0 or 24, CSN rising is a clean end.
- SCLK edges while CSN is high are ignored.

## Timing

- spi_csn, spi_sclk and spi_mosi each pass through a 2-flop synchronizer. Edge detection uses a third flop.
  - Internal edge events lag the pins by 3 clk cycles.
  - MOSI is sampled from its synchronized copy on the rising-edge event. This requires MOSI to be stable at least 4 clk around the SCLK rise.
- Write commit: wr_strobe, the cfg_regs update and wr_addr/wr_data all occur in the same cycle, exactly 1 clk after the 24th rising-edge event.
- Read timing:
  - Register data is captured 1 clk after the 16th rising-edge event.
  - spi_miso_oe rises with the falling-edge event that follows, and spi_miso presents data bit 7 on that same event.
  - Each later falling event shifts out the next bit.
  - spi_miso_oe and spi_miso go to 0 on the falling event after the 24th rise, or on CSN rising.
- spi_miso is 0 whenever spi_miso_oe is 0.
- frame_err is asserted 1 clk after the CSN rising event.
- A register changed by a write is visible to a read in the next frame.
- Reset values: spi_miso 0, spi_miso_oe 0, wr_strobe 0, wr_addr 0, wr_data 0, frame_err 0, all cfg_regs 0, state IDLE, bit_cnt 0.
- Reset asserted mid-frame aborts the frame silently: no frame_err. After release, the block waits for a fresh CSN falling edge. A CSN that is already low at release is ignored until it goes high.

## Structure

- Package spi_resp_pkg holds:
  - FRAME_BITS = 24, INSTR_BITS = 16, ADDR_W = 15, DATA_W = 8;
  - the state encoding (IDLE, INSTR, WDATA, RDATA, DONE).
- Sub-module spi_sync_edge: a 2-flop synchronizer plus edge detector, instantiated once each for csn, sclk and mosi. It outputs the synchronized level, a rise pulse and a fall pulse.
- The top level holds the FSM, the 5-bit bit_cnt, the rx/tx shift registers and the register file.

## Test plan

- Write frame 0x000A5C (addr 0x000A, data 0x5C) at SCLK = clk/8: one wr_strobe, wr_addr = 0x000A, wr_data = 0x5C, cfg_regs[87:80] = 0x5C, frame_err = 0.
- Read frame 0x800A00 after the write above: spi_miso shifts 0x5C MSB first on bits 16–23, spi_miso_oe high for exactly those 8 bits, no wr_strobe.
- Write to addr 0x0123 (unimplemented with NUM_REGS = 16): no wr_strobe, cfg_regs unchanged. A read of 0x0123 returns 0x00.
- CSN deasserted after 10 bits of a write: one frame_err pulse, no wr_strobe, registers unchanged. The next full frame works normally.
- 30 SCLK pulses in one CSN window with a write of 0x33 to addr 3: a single commit at bit 24, extra bits ignored, cfg_regs[31:24] = 0x33.
- rstn asserted after 20 bits of a write: all outputs return to reset values, no commit, no frame_err.
